cpu_checker_pro: RTL

CPU_CHECKER_PRO -- requirements
Module: cpu_checker_pro

---
 rtl/cpu_checker_pkg.sv | 40 ++++
 rtl/cpu_checker_char_decode.sv | 30 +++
 rtl/cpu_checker_pro.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_checker_pkg.sv
// cpu_checker_pkg: shared types and constants for the CPU trace-line checker.
//   state_t      parser states
//   FMT_*        format_type encodings
//   ERR_*        bit positions inside error_code
//   dec_width()  bits needed to hold an N-digit decimal number without loss
package cpu_checker_pkg;

  typedef enum logic [3:0] {
    IDLE, TIME, PC, COLON_SP, REG, ADDR, SP1, LT, SP2, DATA, DONE, ERR
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;

  localparam logic [7:0] CH_CARET = 8'h5e;  // '^'
  localparam logic [7:0] CH_AT    = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON = 8'h3a;  // ':'
  localparam logic [7:0] CH_SPACE = 8'h20;  // ' '
  localparam logic [7:0] CH_DOLLAR= 8'h24;  // '$'
  localparam logic [7:0] CH_STAR  = 8'h2a;  // '*'
  localparam logic [7:0] CH_LT    = 8'h3c;  // '<'
  localparam logic [7:0] CH_EQ    = 8'h3d;  // '='
  localparam logic [7:0] CH_HASH  = 8'h23;  // '#'

  // ceil(log2(10^digits)); 10^digits is never a power of two, so this
  // always covers the largest value 10^digits - 1.
  function automatic int dec_width(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return $clog2(v);
  endfunction

endpackage

// File: rtl/cpu_checker_char_decode.sv
// cpu_checker_char_decode: combinational ASCII classifier.
//   char   in  8  ASCII character
//   is_dec out 1  '0'..'9'
//   is_hex out 1  '0'..'9', 'a'..'f', 'A'..'F'
//   nib    out 4  value of the hex/decimal digit (0 when not a digit)
module cpu_checker_char_decode (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nib
);

  always_comb begin
    is_dec = 1'b0;
    is_hex = 1'b0;
    nib    = 4'd0;
    if (char >= 8'h30 && char <= 8'h39) begin
      is_dec = 1'b1;
      is_hex = 1'b1;
      nib    = 4'(char - 8'h30);
    end else if (char >= 8'h61 && char <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(char - 8'h61 + 8'd10);
    end else if (char >= 8'h41 && char <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(char - 8'h41 + 8'd10);
    end
  end

endmodule

// File: rtl/cpu_checker_pro.sv
// cpu_checker_pro: streaming parser/checker for CPU write-trace lines
//   ^<time>@<pc8>: [sp] ($<reg> | *<addr8>) [sp] <= [sp] <data8>#
// One character is consumed per clock. One cycle after a complete '#',
// format_type/error_code carry the result for exactly one cycle.
//   clk          in  1       rising-edge clock
//   reset        in  1       synchronous, active-high
//   char         in  8       ASCII input
//   freq         in  FREQ_W  power of two >= 2, stable during a message
//   format_type  out 2       0 none, 1 register write, 2 memory write
//   error_code   out 4       bit0 time, bit1 pc, bit2 addr, bit3 grf
// Optional (CPU_CHECKER_STATS_EN defined):
//   msg_count    out 16      saturating count of completed messages
//   err_count    out 16      saturating count of messages with errors
module cpu_checker_pro
  import cpu_checker_pkg::*;
#(
  parameter int          TIME_DIGITS = 4,
  parameter int          REG_DIGITS  = 4,
  parameter int          NUM_REGS    = 32,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4fff,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
  parameter int          FREQ_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [FREQ_W-1:0] freq,
  output logic [1:0]        format_type,
  output logic [3:0]        error_code
`ifdef CPU_CHECKER_STATS_EN
  ,
  output logic [15:0]       msg_count,
  output logic [15:0]       err_count
`endif
);

  localparam int TIME_W = dec_width(TIME_DIGITS);
  localparam int REG_W  = dec_width(REG_DIGITS);
  localparam int MAXD   = (TIME_DIGITS > 8) ? ((TIME_DIGITS > REG_DIGITS) ? TIME_DIGITS : REG_DIGITS)
                        : ((REG_DIGITS > 8) ? REG_DIGITS : 8);
  localparam int CNT_W  = $clog2(MAXD + 1);
  localparam int TCW    = (TIME_W > FREQ_W) ? TIME_W : FREQ_W;
  localparam int RCW    = (REG_W > 32) ? REG_W : 32;

  state_t            state, state_n;
  logic [TIME_W-1:0] time_acc, time_n;
  logic [REG_W-1:0]  reg_acc, reg_n;
  logic [31:0]       pc, pc_n, addr, addr_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic              is_mem, mem_n;
  logic [1:0]        fmt_n;
  logic [3:0]        err_n;
  logic              is_dec, is_hex;
  logic [3:0]        nib;
  logic [FREQ_W-1:0] fmask;

  cpu_checker_char_decode u_dec (
    .char   (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nib    (nib)
  );

  // State and field registers; reset wins over any character.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      time_acc    <= '0;
      reg_acc     <= '0;
      pc          <= '0;
      addr        <= '0;
      cnt         <= '0;
      is_mem      <= 1'b0;
      format_type <= FMT_NONE;
      error_code  <= '0;
    end else begin
      state       <= state_n;
      time_acc    <= time_n;
      reg_acc     <= reg_n;
      pc          <= pc_n;
      addr        <= addr_n;
      cnt         <= cnt_n;
      is_mem      <= mem_n;
      format_type <= fmt_n;
      error_code  <= err_n;
    end
  end

  // Next-state and field accumulation. cnt counts digits of the current field.
  always_comb begin
    state_n = state;
    time_n  = time_acc;
    reg_n   = reg_acc;
    pc_n    = pc;
    addr_n  = addr;
    cnt_n   = cnt;
    mem_n   = is_mem;
    cnt_inc = cnt + CNT_W'(1);
    if (char == CH_CARET) begin
      state_n = TIME;
      time_n  = '0;
      reg_n   = '0;
      pc_n    = '0;
      addr_n  = '0;
      cnt_n   = '0;
      mem_n   = 1'b0;
    end else begin
      case (state)
        IDLE, ERR: state_n = state;
        DONE:      state_n = IDLE;
        TIME:
          if (is_dec && cnt < CNT_W'(TIME_DIGITS)) begin
            time_n = time_acc * TIME_W'(10) + TIME_W'(nib);
            cnt_n  = cnt_inc;
          end else if (char == CH_AT && cnt != '0) begin
            state_n = PC;
            cnt_n   = '0;
          end else state_n = ERR;
        PC:
          if (is_hex && cnt < CNT_W'(8)) begin
            pc_n  = {pc[27:0], nib};
            cnt_n = cnt_inc;
          end else if (char == CH_COLON && cnt == CNT_W'(8)) begin
            state_n = COLON_SP;
            cnt_n   = '0;
          end else state_n = ERR;
        COLON_SP:
          if (char == CH_SPACE)       state_n = COLON_SP;
          else if (char == CH_DOLLAR) state_n = REG;
          else if (char == CH_STAR) begin
            state_n = ADDR;
            mem_n   = 1'b1;
          end else state_n = ERR;
        REG:
          if (is_dec && cnt < CNT_W'(REG_DIGITS)) begin
            reg_n = reg_acc * REG_W'(10) + REG_W'(nib);
            cnt_n = cnt_inc;
          end else if (char == CH_SPACE && cnt != '0) state_n = SP1;
          else if (char == CH_LT && cnt != '0)         state_n = LT;
          else state_n = ERR;
        ADDR:
          if (is_hex && cnt < CNT_W'(8)) begin
            addr_n = {addr[27:0], nib};
            cnt_n  = cnt_inc;
          end else if (char == CH_SPACE && cnt == CNT_W'(8)) state_n = SP1;
          else if (char == CH_LT && cnt == CNT_W'(8))         state_n = LT;
          else state_n = ERR;
        SP1:
          if (char == CH_SPACE)   state_n = SP1;
          else if (char == CH_LT) state_n = LT;
          else state_n = ERR;
        LT:
          state_n = (char == CH_EQ) ? SP2 : ERR;
        SP2:
          if (char == CH_SPACE) state_n = SP2;
          else if (is_hex) begin
            state_n = DATA;
            cnt_n   = CNT_W'(1);
          end else state_n = ERR;
        DATA:
          // Data value is not checked, only its digit count.
          if (is_hex && cnt < CNT_W'(8))                     cnt_n   = cnt_inc;
          else if (char == CH_HASH && cnt == CNT_W'(8))     state_n = DONE;
          else state_n = ERR;
        default: state_n = ERR;
      endcase
    end
  end

  // Result for the DONE cycle, registered on the edge that enters DONE.
  // All fields are already complete at that point ('#' adds nothing).
  assign fmask = (freq >> 1) - FREQ_W'(1);

  always_comb begin
    fmt_n = FMT_NONE;
    err_n = '0;
    if (state_n == DONE) begin
      fmt_n           = is_mem ? FMT_MEM : FMT_REG;
      err_n[ERR_TIME] = |(TCW'(time_acc) & TCW'(fmask));
      err_n[ERR_PC]   = (pc < PC_LO) || (pc > PC_HI) || (pc[1:0] != 2'b00);
      if (is_mem) err_n[ERR_ADDR] = (addr > ADDR_HI) || (addr[1:0] != 2'b00);
      else        err_n[ERR_GRF]  = RCW'(reg_acc) >= RCW'(NUM_REGS);
    end
  end

`ifdef CPU_CHECKER_STATS_EN
  // Outputs are valid while in DONE, so count on the edge leaving it.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_count <= '0;
      err_count <= '0;
    end else if (state == DONE) begin
      if (msg_count != 16'hffff) msg_count <= msg_count + 16'd1;
      if (error_code != 4'd0 && err_count != 16'hffff) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
